imc_mm_arbiter: RTL and testbench

IMC_MM_ARBITER -- requirements
Module: imc_mm_arbiter

---
 rtl/imc_mm_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_imc_mm_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imc_mm_arbiter.sv
// ---------------------------------------------------------------------------------------------
// imc_mm_arbiter
//   Two-master arbiter in front of the IMC datapath slave. Master 0 is the NIOS host and
//   master 1 is the PROM sequencer. The grant is registered, so a forwarded command appears
//   one cycle after the request. Ties go round-robin. Master 1 can hold the bus across
//   consecutive commands with m1_lock_in. Accepted reads push the issuing master ID into a
//   tag FIFO. Each slave readdatavalid pops the FIFO head and routes the response to that
//   master.
//
// Ports
//   sys_clk_in, sys_reset_in             clock, async active-low reset
//   m0_*_in / m0_*_out                   host command in, waitrequest/readdata/valid out
//   m1_*_in / m1_*_out, m1_lock_in       PROM sequencer command/response, bus lock
//   s_*_out / s_*_in                     command to IMC slave, slave response back
//   rsp_error_out                        sticky: response arrived with no outstanding read
// ---------------------------------------------------------------------------------------------
module imc_mm_arbiter #(
  parameter int unsigned ADDR_BITS       = 9,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                 sys_clk_in,
  input  logic                 sys_reset_in,

  input  logic [31:0]          m0_writedata_in,
  input  logic [ADDR_BITS-1:0] m0_address_in,
  input  logic                 m0_write_in,
  input  logic                 m0_read_in,
  output logic                 m0_waitrequest_out,
  output logic [31:0]          m0_readdata_out,
  output logic                 m0_readdatavalid_out,

  input  logic [31:0]          m1_writedata_in,
  input  logic [ADDR_BITS-1:0] m1_address_in,
  input  logic                 m1_write_in,
  input  logic                 m1_read_in,
  output logic                 m1_waitrequest_out,
  output logic [31:0]          m1_readdata_out,
  output logic                 m1_readdatavalid_out,
  input  logic                 m1_lock_in,

  output logic [31:0]          s_writedata_out,
  output logic [ADDR_BITS-1:0] s_address_out,
  output logic                 s_write_out,
  output logic                 s_read_out,
  input  logic                 s_waitrequest_in,
  input  logic [31:0]          s_readdata_in,
  input  logic                 s_readdatavalid_in,

  output logic                 rsp_error_out
);

  localparam int unsigned PtrW = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGnt0 = 2'd1,
    StGnt1 = 2'd2
  } state_e;

  state_e r_state;
  state_e w_state_next;
  logic   r_rr_last;  // master of the most recent accept; 1 out of reset so m0 wins first tie

  logic [MAX_OUTSTANDING-1:0] r_tags;
  logic [PtrW-1:0]            r_wr_ptr;
  logic [PtrW-1:0]            r_rd_ptr;
  logic [CntW-1:0]            r_count;
  logic                       r_rsp_error;

  logic w_m0_req;
  logic w_m1_req;
  logic w_sel1;
  logic w_granted;
  logic w_cmd_wr;
  logic w_cmd_rd;
  logic w_fifo_empty;
  logic w_fifo_full;
  logic w_pop;
  logic w_push;
  logic w_blocked;
  logic w_accept;
  logic w_head;

  // ------------------------------------------------------------------------------------------
  // Request decode and forwarding
  // ------------------------------------------------------------------------------------------
  assign w_m0_req  = m0_read_in | m0_write_in;
  assign w_m1_req  = m1_read_in | m1_write_in;
  assign w_sel1    = (r_state == StGnt1);
  assign w_granted = (r_state != StIdle);

  // Read+write together is a write; the read strobe is dropped.
  assign w_cmd_wr = w_granted & (w_sel1 ? m1_write_in : m0_write_in);
  assign w_cmd_rd = w_granted & (w_sel1 ? (m1_read_in & ~m1_write_in)
                                        : (m0_read_in & ~m0_write_in));

  assign w_fifo_empty = (r_count == '0);
  assign w_fifo_full  = (r_count == MaxCnt);
  assign w_pop        = s_readdatavalid_in & ~w_fifo_empty;

  // A pop in the same cycle frees the slot, so a full FIFO only blocks without a response.
  assign w_blocked = w_cmd_rd & w_fifo_full & ~w_pop;
  assign w_accept  = (w_cmd_rd | w_cmd_wr) & ~s_waitrequest_in & ~w_blocked;
  assign w_push    = w_accept & w_cmd_rd;

  assign s_writedata_out = w_sel1 ? m1_writedata_in : m0_writedata_in;
  assign s_address_out   = w_sel1 ? m1_address_in   : m0_address_in;
  assign s_write_out     = w_cmd_wr;
  assign s_read_out      = w_cmd_rd & ~w_blocked;

  assign m0_waitrequest_out = ~(w_accept & (r_state == StGnt0));
  assign m1_waitrequest_out = ~(w_accept & w_sel1);

  // ------------------------------------------------------------------------------------------
  // Response routing
  // ------------------------------------------------------------------------------------------
  assign w_head               = r_tags[r_rd_ptr];
  assign m0_readdata_out      = s_readdata_in;
  assign m1_readdata_out      = s_readdata_in;
  assign m0_readdatavalid_out = w_pop & ~w_head;
  assign m1_readdatavalid_out = w_pop & w_head;
  assign rsp_error_out        = r_rsp_error;

  // ------------------------------------------------------------------------------------------
  // Grant FSM
  // ------------------------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_m0_req && w_m1_req) begin
          w_state_next = r_rr_last ? StGnt0 : StGnt1;
        end else if (w_m0_req) begin
          w_state_next = StGnt0;
        end else if (w_m1_req) begin
          w_state_next = StGnt1;
        end
      end
      StGnt0: begin
        if (w_accept) begin
          if (w_m1_req)      w_state_next = StGnt1;
          else if (w_m0_req) w_state_next = StGnt0;
          else               w_state_next = StIdle;
        end else if (!w_m0_req) begin
          w_state_next = StIdle;
        end
      end
      StGnt1: begin
        if (w_accept) begin
          if (m1_lock_in)    w_state_next = StGnt1;
          else if (w_m0_req) w_state_next = StGnt0;
          else if (w_m1_req) w_state_next = StGnt1;
          else               w_state_next = StIdle;
        end else if (!w_m1_req && !m1_lock_in) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk_in or negedge sys_reset_in) begin
    if (!sys_reset_in) begin
      r_state   <= StIdle;
      r_rr_last <= 1'b1;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_rr_last <= w_sel1;
      end
    end
  end

  // ------------------------------------------------------------------------------------------
  // Read-tag FIFO; pointers wrap naturally since depth is a power of two
  // ------------------------------------------------------------------------------------------
  always_ff @(posedge sys_clk_in or negedge sys_reset_in) begin
    if (!sys_reset_in) begin
      r_tags      <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rsp_error <= 1'b0;
    end else begin
      if (w_push) begin
        r_tags[r_wr_ptr] <= w_sel1;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (s_readdatavalid_in && w_fifo_empty) begin
        r_rsp_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imc_mm_arbiter.sv
// Directed bench for imc_mm_arbiter (ADDR_BITS=9, MAX_OUTSTANDING=4). Inputs change 1 ns
// after each rising edge; outputs are checked 1 ns later, well before the next edge.
module tb_imc_mm_arbiter;

  logic        clk;
  logic        rst_n;
  logic [31:0] m0_wd, m1_wd, s_wd, s_rd, m0_rd, m1_rd;
  logic [8:0]  m0_addr, m1_addr, s_addr;
  logic        m0_wr, m0_rdq, m0_wait, m0_rdv;
  logic        m1_wr, m1_rdq, m1_wait, m1_rdv, m1_lock;
  logic        s_wr, s_rdq, s_wait, s_rdv;
  logic        rsp_err;

  int n_checks = 0;
  int n_errors = 0;

  imc_mm_arbiter #(
    .ADDR_BITS       (9),
    .MAX_OUTSTANDING (4)
  ) u_dut (
    .sys_clk_in           (clk),
    .sys_reset_in         (rst_n),
    .m0_writedata_in      (m0_wd),
    .m0_address_in        (m0_addr),
    .m0_write_in          (m0_wr),
    .m0_read_in           (m0_rdq),
    .m0_waitrequest_out   (m0_wait),
    .m0_readdata_out      (m0_rd),
    .m0_readdatavalid_out (m0_rdv),
    .m1_writedata_in      (m1_wd),
    .m1_address_in        (m1_addr),
    .m1_write_in          (m1_wr),
    .m1_read_in           (m1_rdq),
    .m1_waitrequest_out   (m1_wait),
    .m1_readdata_out      (m1_rd),
    .m1_readdatavalid_out (m1_rdv),
    .m1_lock_in           (m1_lock),
    .s_writedata_out      (s_wd),
    .s_address_out        (s_addr),
    .s_write_out          (s_wr),
    .s_read_out           (s_rdq),
    .s_waitrequest_in     (s_wait),
    .s_readdata_in        (s_rd),
    .s_readdatavalid_in   (s_rdv),
    .rsp_error_out        (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    m0_wd = '0; m0_addr = '0; m0_wr = 1'b0; m0_rdq = 1'b0;
    m1_wd = '0; m1_addr = '0; m1_wr = 1'b0; m1_rdq = 1'b0; m1_lock = 1'b0;
    s_wait = 1'b0; s_rd = '0; s_rdv = 1'b0;
  endtask

  // Outputs that must hold whenever reset is asserted.
  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".s_read"},  s_rdq,   0);
    check_eq({tag, ".s_write"}, s_wr,    0);
    check_eq({tag, ".m0_wait"}, m0_wait, 1);
    check_eq({tag, ".m1_wait"}, m1_wait, 1);
    check_eq({tag, ".m0_rdv"},  m0_rdv,  0);
    check_eq({tag, ".m1_rdv"},  m1_rdv,  0);
    check_eq({tag, ".rsp_err"}, rsp_err, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #2;
    check_reset_outputs("rst");
    step();
    step();
    rst_n = 1'b1;
    step();

    // ---- Both masters read together; m0 wins first tie, responses routed in order ----
    m0_rdq = 1'b1; m0_addr = 9'h010;
    m1_rdq = 1'b1; m1_addr = 9'h020;
    settle();
    check_eq("a.c0.s_read", s_rdq, 0);
    check_eq("a.c0.m0_wait", m0_wait, 1);
    step();                                        // cycle 1: GNT0
    settle();
    check_eq("a.c1.s_read", s_rdq, 1);
    check_eq("a.c1.s_addr", s_addr, 9'h010);
    check_eq("a.c1.m0_wait", m0_wait, 0);
    check_eq("a.c1.m1_wait", m1_wait, 1);
    step();                                        // cycle 2: GNT1
    m0_rdq = 1'b0;
    settle();
    check_eq("a.c2.s_addr", s_addr, 9'h020);
    check_eq("a.c2.m1_wait", m1_wait, 0);
    check_eq("a.c2.m0_wait", m0_wait, 1);
    step();                                        // cycle 3: m0 response
    m1_rdq = 1'b0;
    s_rdv = 1'b1; s_rd = 32'hAAAA_0001;
    settle();
    check_eq("a.c3.s_read", s_rdq, 0);
    check_eq("a.c3.m0_rdv", m0_rdv, 1);
    check_eq("a.c3.m1_rdv", m1_rdv, 0);
    check_eq("a.c3.m0_data", m0_rd, 32'hAAAA_0001);
    step();                                        // cycle 4: m1 response
    s_rd = 32'hBBBB_0002;
    settle();
    check_eq("a.c4.m1_rdv", m1_rdv, 1);
    check_eq("a.c4.m0_rdv", m0_rdv, 0);
    check_eq("a.c4.m1_data", m1_rd, 32'hBBBB_0002);
    step();
    s_rdv = 1'b0;
    settle();
    check_eq("a.rsp_err", rsp_err, 0);
    step();

    // ---- Slave waitrequest held 3 cycles during m0 write; m1 read waits ----
    m0_wr = 1'b1; m0_addr = 9'h1A5; m0_wd = 32'h1234_5678;
    m1_rdq = 1'b1; m1_addr = 9'h033;
    s_wait = 1'b1;
    step();
    for (int i = 1; i <= 3; i++) begin
      settle();
      check_eq($sformatf("b.c%0d.s_addr", i), s_addr, 9'h1A5);
      check_eq($sformatf("b.c%0d.s_write", i), s_wr, 1);
      check_eq($sformatf("b.c%0d.m0_wait", i), m0_wait, 1);
      check_eq($sformatf("b.c%0d.m1_wait", i), m1_wait, 1);
      step();
    end
    s_wait = 1'b0;                                 // cycle 4
    settle();
    check_eq("b.c4.m0_wait", m0_wait, 0);
    check_eq("b.c4.s_wdata", s_wd, 32'h1234_5678);
    step();                                        // cycle 5: m1 read
    m0_wr = 1'b0;
    settle();
    check_eq("b.c5.m1_wait", m1_wait, 0);
    check_eq("b.c5.s_read", s_rdq, 1);
    check_eq("b.c5.s_addr", s_addr, 9'h033);
    step();
    m1_rdq = 1'b0;
    s_rdv = 1'b1; s_rd = 32'hCAFE_0003;
    settle();
    check_eq("b.c6.m1_rdv", m1_rdv, 1);
    check_eq("b.c6.m0_rdv", m0_rdv, 0);
    step();
    s_rdv = 1'b0;
    step();

    // ---- m1 locked for 3 writes while m0 keeps reading ----
    m1_wr = 1'b1; m1_lock = 1'b1; m1_addr = 9'h101; m1_wd = 32'd1;
    step();                                        // cycle 1: GNT1
    m0_rdq = 1'b1; m0_addr = 9'h044;
    settle();
    check_eq("c.w1.m1_wait", m1_wait, 0);
    check_eq("c.w1.s_addr", s_addr, 9'h101);
    check_eq("c.w1.m0_wait", m0_wait, 1);
    step();
    m1_addr = 9'h102; m1_wd = 32'd2;
    settle();
    check_eq("c.w2.m1_wait", m1_wait, 0);
    check_eq("c.w2.s_addr", s_addr, 9'h102);
    check_eq("c.w2.m0_wait", m0_wait, 1);
    step();
    m1_addr = 9'h103; m1_wd = 32'd3; m1_lock = 1'b0;
    settle();
    check_eq("c.w3.m1_wait", m1_wait, 0);
    check_eq("c.w3.s_wdata", s_wd, 32'd3);
    check_eq("c.w3.m0_wait", m0_wait, 1);
    step();
    m1_wr = 1'b0;
    settle();
    check_eq("c.r.m0_wait", m0_wait, 0);
    check_eq("c.r.s_read", s_rdq, 1);
    check_eq("c.r.s_addr", s_addr, 9'h044);
    step();
    m0_rdq = 1'b0;
    s_rdv = 1'b1; s_rd = 32'h0000_0044;
    settle();
    check_eq("c.rsp.m0_rdv", m0_rdv, 1);
    step();
    s_rdv = 1'b0;
    step();

    // ---- 5 reads from m0 with depth 4: 5th blocked until a response pops ----
    m0_rdq = 1'b1; m0_addr = 9'h050;
    step();
    for (int i = 1; i <= 4; i++) begin
      settle();
      check_eq($sformatf("d.rd%0d.m0_wait", i), m0_wait, 0);
      step();
    end
    for (int i = 5; i <= 6; i++) begin
      settle();
      check_eq($sformatf("d.blk%0d.s_read", i), s_rdq, 0);
      check_eq($sformatf("d.blk%0d.m0_wait", i), m0_wait, 1);
      step();
    end
    s_rdv = 1'b1; s_rd = 32'h5555_0001;
    settle();
    check_eq("d.pop.m0_rdv", m0_rdv, 1);
    check_eq("d.pop.s_read", s_rdq, 1);
    check_eq("d.pop.m0_wait", m0_wait, 0);
    step();
    m0_rdq = 1'b0;
    for (int i = 0; i < 4; i++) begin                // drain remaining 4 tags, all m0
      settle();
      check_eq($sformatf("d.drain%0d.m0_rdv", i), m0_rdv, 1);
      check_eq($sformatf("d.drain%0d.m1_rdv", i), m1_rdv, 0);
      step();
    end
    s_rdv = 1'b0;
    settle();
    check_eq("d.rsp_err", rsp_err, 0);
    step();

    // ---- Response with empty FIFO: no valid, sticky error ----
    s_rdv = 1'b1; s_rd = 32'hDEAD_BEEF;
    settle();
    check_eq("e.orph.m0_rdv", m0_rdv, 0);
    check_eq("e.orph.m1_rdv", m1_rdv, 0);
    step();
    s_rdv = 1'b0;
    settle();
    check_eq("e.err.set", rsp_err, 1);
    step();
    step();
    check_eq("e.err.sticky", rsp_err, 1);

    // ---- Reset mid-transaction discards outstanding tags ----
    m0_rdq = 1'b1; m0_addr = 9'h060;
    step();                                        // GNT0, accepted here
    step();
    m0_rdq = 1'b0;
    m1_wr = 1'b1; m1_addr = 9'h0FF; s_wait = 1'b1;
    step();                                        // GNT0 with no request -> IDLE
    step();                                        // IDLE -> GNT1
    settle();
    check_eq("e.pre.s_write", s_wr, 1);
    rst_n = 1'b0;
    s_rdv = 1'b1;
    settle();
    check_reset_outputs("e.rst");
    step();
    idle_inputs();
    rst_n = 1'b1;
    step();
    m0_wr = 1'b1; m0_addr = 9'h011;
    m1_wr = 1'b1; m1_addr = 9'h022;
    step();
    settle();
    check_eq("e.tie.m0_wait", m0_wait, 0);
    check_eq("e.tie.m1_wait", m1_wait, 1);
    check_eq("e.tie.s_addr", s_addr, 9'h011);
    idle_inputs();
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
